// File: rtl/data_memory_bw.sv
// data_memory_bw: byte-addressable data memory with byte/half/word loads and stores.
// It uses a request/ready handshake with a fixed access latency and flags misaligned accesses.
// After reset it can sweep every word to zero before it accepts requests.
module data_memory_bw #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned LATENCY    = 2,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_err,
  output logic        o_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned BA_W  = ADDR_WIDTH + 2;
  localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q, sweep_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [BA_W-1:0]         addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    ready_q, ready_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  logic [31:0]             mem_q [DEPTH];
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_idx;
  logic [31:0]             mem_wdata;

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              lane;
  logic [31:0]             cur_word;
  logic                    misaligned;
  logic [3:0]              be;
  logic [31:0]             wr_lanes;
  logic [31:0]             merged;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [31:0]             load_val;
  logic                    unused_addr_bits;

  assign word_idx         = addr_q[BA_W-1:2];
  assign lane             = addr_q[1:0];
  assign cur_word         = mem_q[word_idx];
  assign unused_addr_bits = ^i_addr[31:BA_W];

  // Flag halfword/word accesses that are not naturally aligned, and flag the illegal size code
  always_comb begin
    misaligned = 1'b0;
    unique case (size_q)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Merge store data into the addressed lanes of the current word
  always_comb begin
    be       = 4'b0000;
    wr_lanes = wdata_q;
    merged   = cur_word;
    unique case (size_q)
      2'b00: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_q[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = wr_lanes[8*k +: 8];
    end
  end

  // Extract the addressed byte/half and sign- or zero-extend it
  always_comb begin
    byte_sel = cur_word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = cur_word;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (!INIT_CLEAR || (sweep_q == '1)) state_d = ST_IDLE;
      ST_IDLE: if (i_req) state_d = ST_BUSY;
      ST_BUSY: if (lat_q == '0) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    sweep_d   = sweep_q;
    lat_d     = lat_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_wdata = merged;
    unique case (state_q)
      ST_INIT: begin
        sweep_d = ADDR_WIDTH'(sweep_q + 1'b1);
        if (INIT_CLEAR) begin
          mem_we    = 1'b1;
          mem_idx   = sweep_q;
          mem_wdata = '0;
        end
      end
      ST_IDLE: begin
        if (i_req) begin
          we_d    = i_we;
          size_d  = i_size;
          uns_d   = i_unsigned;
          addr_d  = i_addr[BA_W-1:0];
          wdata_d = i_wdata;
          lat_d   = LAT_LOAD;
        end
      end
      ST_BUSY: begin
        if (lat_q == '0) begin
          ready_d = 1'b1;
          err_d   = misaligned;
          if (misaligned) rdata_d = '0;
          else if (we_q)  mem_we  = 1'b1;
          else            rdata_d = load_val;
        end else begin
          lat_d = LAT_W'(lat_q - 1'b1);
        end
      end
      default: ;
    endcase
    // A store that completes on a reset edge is dropped
    if (i_rst) mem_we = 1'b0;
    busy_d = (state_d != ST_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sweep_q <= '0;
      lat_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      sweep_q <= sweep_d;
      lat_q   <= lat_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array, written by the init sweep or by a completing store
  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end

  assign o_rdata = rdata_q;
  assign o_ready = ready_q;
  assign o_err   = err_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_data_memory_bw.sv
// tb_data_memory_bw: directed plus randomized accesses checked against a byte-array memory model.
module tb_data_memory_bw;

  localparam int unsigned AW  = 5;
  localparam int unsigned LAT = 3;
  localparam int unsigned NB  = 4 * (2 ** AW);

  logic        clk;
  logic        i_rst;
  logic        i_req;
  logic        i_we;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_err;
  logic        o_busy;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mdl_mem [NB];
  logic [31:0] exp_rdata;

  data_memory_bw #(
    .ADDR_WIDTH (AW),
    .LATENCY    (LAT),
    .INIT_CLEAR (1'b1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_size     (i_size),
    .i_unsigned (i_unsigned),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_ready    (o_ready),
    .o_err      (o_err),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit mdl_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  endfunction

  // Byte-level reference: little-endian bytes, extension computed arithmetically
  task automatic mdl_apply(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int base;
    int nbytes;
    logic [31:0] v;
    base = int'(addr % NB);
    if (mdl_err(size, addr)) begin
      exp_rdata = 32'h0;
    end else begin
      nbytes = 1 << size;
      if (we) begin
        for (int i = 0; i < nbytes; i++) mdl_mem[base + i] = wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mdl_mem[base + i];
        if (!uns && nbytes < 4 && v[8*nbytes - 1]) v = v | ~((32'h1 << (8*nbytes)) - 32'h1);
        exp_rdata = v;
      end
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NB; i++) mdl_mem[i] = 8'h00;
    exp_rdata = 32'h0;
  endtask

  // Issue one access at a negedge in IDLE; noise on the inputs while BUSY must be ignored
  task automatic access(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input bit chain);
    int n;
    bit e;
    i_req      = 1'b1;
    i_we       = we;
    i_size     = size;
    i_unsigned = uns;
    i_addr     = addr;
    i_wdata    = wdata;
    e = mdl_err(size, addr);
    mdl_apply(we, size, uns, addr, wdata);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!o_ready) begin
        i_req      = 1'($urandom_range(0, 1));
        i_we       = 1'($urandom_range(0, 1));
        i_size     = 2'($urandom_range(0, 3));
        i_unsigned = 1'($urandom_range(0, 1));
        i_addr     = $urandom;
        i_wdata    = $urandom;
      end
    end while (!o_ready && n < 20);
    check({tag, "/latency"}, 32'(n), 32'(LAT + 1));
    check({tag, "/err"}, 32'(o_err), 32'(e));
    check({tag, "/rdata"}, o_rdata, exp_rdata);
    check({tag, "/busy_in_ready"}, 32'(o_busy), 32'h0);
    if (!chain) begin
      i_req = 1'b0;
      @(negedge clk);
      check({tag, "/ready_width"}, 32'(o_ready), 32'h0);
      check({tag, "/err_idle"}, 32'(o_err), 32'h0);
    end
  endtask

  // Reset for 'hold' cycles, then measure the init sweep length
  task automatic do_reset(input string tag, input int hold);
    int n;
    int rdy;
    i_rst = 1'b1;
    i_req = 1'b0;
    repeat (hold) @(negedge clk);
    i_rst = 1'b0;
    check({tag, "/rst_rdata"}, o_rdata, 32'h0);
    check({tag, "/rst_ready"}, 32'(o_ready), 32'h0);
    check({tag, "/rst_err"}, 32'(o_err), 32'h0);
    check({tag, "/rst_busy"}, 32'(o_busy), 32'h1);
    n   = 0;
    rdy = 0;
    while (o_busy && n < 200) begin
      n++;
      if (o_ready) rdy++;
      @(negedge clk);
    end
    mdl_clear();
    check({tag, "/init_len"}, 32'(n), 32'(2 ** AW));
    check({tag, "/init_no_ready"}, 32'(rdy), 32'h0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] saved [8];
    i_rst      = 1'b1;
    i_req      = 1'b0;
    i_we       = 1'b0;
    i_size     = 2'b00;
    i_unsigned = 1'b0;
    i_addr     = 32'h0;
    i_wdata    = 32'h0;
    mdl_clear();
    @(negedge clk);

    do_reset("reset0", 2);
    access("lw_7c", 1'b0, 2'b10, 1'b0, 32'h7C, 32'h0, 1'b0);

    access("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
    access("sb_12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB, 1'b0);
    access("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    access("lb_12", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 1'b0);
    access("lbu_12", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);

    access("sh_16", 1'b1, 2'b01, 1'b0, 32'h16, 32'h00008001, 1'b0);
    access("lw_14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);
    access("lh_16", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 1'b0);
    access("lhu_16", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 1'b0);

    access("lw_13", 1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0);
    access("sh_11", 1'b1, 2'b01, 1'b0, 32'h11, 32'h0000FFFF, 1'b0);
    access("lw_10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
    access("size11", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1'b0);
    access("lw_10c", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);

    access("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFE55AA, 1'b1);
    access("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    access("b2b_lhu", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 1'b0);

    access("alias_sw", 1'b1, 2'b10, 1'b0, 32'hFFFF_FF84, 32'h0BADF00D, 1'b0);
    access("alias_lw", 1'b0, 2'b10, 1'b0, 32'h04, 32'h0, 1'b0);

    for (int t = 0; t < 80; t++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      access($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
             a, $urandom, 1'($urandom_range(0, 1)));
    end
    i_req = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      saved[i] = 32'(i * 16 + 4 * $urandom_range(0, 3));
      access($sformatf("fill%0d", i), 1'b1, 2'b10, 1'b0, saved[i], 32'hA5A50000 | 32'(i + 1), 1'b0);
    end
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    repeat (10) @(negedge clk);
    do_reset("reset_in_init", 1);
    for (int i = 0; i < 8; i++) access($sformatf("cleared%0d", i), 1'b0, 2'b10, 1'b0, saved[i], 32'h0, 1'b0);

    i_req   = 1'b1;
    i_we    = 1'b1;
    i_size  = 2'b10;
    i_addr  = 32'h20;
    i_wdata = 32'hDEADBEEF;
    @(negedge clk);
    i_req = 1'b0;
    do_reset("reset_mid_store", 1);
    access("lw_20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
